key_expand: RTL and testbench



---
 rtl/key_expand.sv | 153 +++++++++++++++
 tb/tb_key_expand.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_expand.sv
// key_expand: sequential AES-128 key schedule. Emits round keys 0..10 over a
// valid/ready handshake, one expansion step per accepted key, using a single
// row-wide s_box on RotWord(w3).

// One S-box byte lane: FIPS-197 forward S-box as a constant lookup.
module s_box_lane (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);
   // Entry for byte b lives at bits [2047-8b -: 8], so row 0 sits in the MSBs.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // ~b * 8 is the bit offset of entry b counted from the LSB end.
   assign byte_out = SBOX_TBL[{~byte_in, 3'b000} +: 8];
endmodule

// Row-wide substitution: one lane per byte of the row.
module s_box #(
   parameter int NUM_LANES = 4,
   parameter int VEC_W     = 8
) (
   input  logic [NUM_LANES-1:0][VEC_W-1:0] row_in,
   output logic [NUM_LANES-1:0][VEC_W-1:0] row_out
);
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      s_box_lane u_lane (
         .byte_in  (row_in[l]),
         .byte_out (row_out[l])
      );
   end
endmodule

module key_expand (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);
   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   state_t        state_q, state_d;
   logic [127:0]  key_reg;
   logic [3:0]    idx_q;
   logic [7:0]    rcon_q;
   logic          done_q;

   logic          hs, last;
   logic [31:0]   w0, w1, w2, w3, w4, w5, w6, w7, t;
   logic [3:0][7:0] sb_in, sb_out;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign hs   = rk_valid & rk_ready;
   assign last = (idx_q == LAST_ROUND);

   assign {w0, w1, w2, w3} = key_reg;

   // RotWord(w3) goes through the shared S-box row.
   assign sb_in = {w3[23:0], w3[31:24]};

   s_box #(.NUM_LANES(4), .VEC_W(8)) u_s_box (
      .row_in  (sb_in),
      .row_out (sb_out)
   );

   // Next-key words: SubWord(RotWord(w3)) ^ Rcon, then the running xor chain.
   always_comb begin
      t  = sb_out ^ {rcon_q, 24'h0};
      w4 = w0 ^ t;
      w5 = w1 ^ w4;
      w6 = w2 ^ w5;
      w7 = w3 ^ w6;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: start kicks off EMIT, the round-10 handshake returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = EMIT;
         EMIT:    if (hs && last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      rk_valid = 1'b0;
      busy     = 1'b0;
      case (state_q)
         EMIT:    begin rk_valid = 1'b1; busy = 1'b1; end
         default: ;
      endcase
   end

   // Key, index and rcon: load on start, step on each non-final handshake.
   // On the final handshake they hold so the last key stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_reg <= '0;
         idx_q   <= '0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state_q == EMIT) && hs && last;
         if (state_q == IDLE && start) begin
            key_reg <= key_in;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
         end else if (state_q == EMIT && hs && !last) begin
            key_reg <= {w4, w5, w6, w7};
            idx_q   <= idx_q + 4'd1;
            rcon_q  <= xtime(rcon_q);
         end
      end
   end

   assign round_key = key_reg;
   assign round_idx = idx_q;
   assign done      = done_q;
endmodule

// File: tb/tb_key_expand.sv
// Directed bench for key_expand: FIPS-197 and all-zero key schedules, stalls,
// ignored start, mid-run reset and back-to-back expansions.
module tb_key_expand;
   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key_in, round_key;
   logic [3:0]   round_idx;
   logic         rk_valid, busy, done;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_RK [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int total = 0;
   int bad   = 0;

   // Observations gathered by collect()
   logic [127:0] cap_key [0:10];
   int           cap_n, cap_cycles;
   bit           cap_order_ok, cap_stable_ok, cap_early_done, cap_timeout;
   logic         cap_done1, cap_valid1, cap_busy1, cap_done2;

   key_expand dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Present start for the next rising edge.
   task automatic do_start(input logic [127:0] k);
      @(negedge clk);
      key_in = k;
      start  = 1'b1;
   endtask

   // Drive rk_ready and record the accepted keys of one expansion. Optionally
   // pulses start with alt while at inj_idx, and chains a new start in the
   // done cycle.
   task automatic collect(input bit stall, input int inj_idx, input logic [127:0] alt,
                          input bit chain, input logic [127:0] chain_key);
      bit           fin, r, prev_stall;
      logic [127:0] prev_key;
      logic [3:0]   prev_idx;
      fin = 0; prev_stall = 0; prev_key = '0; prev_idx = '0;
      cap_n = 0; cap_cycles = 0;
      cap_order_ok = 1; cap_stable_ok = 1; cap_early_done = 0; cap_timeout = 0;
      for (int i = 0; i <= 10; i++) cap_key[i] = 'x;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) cap_early_done = 1;
         if (rk_valid !== 1'b1) cap_order_ok = 0;
         if (prev_stall && (round_key !== prev_key || round_idx !== prev_idx)) cap_stable_ok = 0;
         r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = r;
         if (rk_valid === 1'b1 && int'(round_idx) == inj_idx) begin
            start  = 1'b1;
            key_in = alt;
         end
         cap_cycles++;
         if (rk_valid === 1'b1 && r) begin
            if (int'(round_idx) != cap_n) cap_order_ok = 0;
            if (cap_n <= 10) cap_key[cap_n] = round_key;
            cap_n++;
            if (round_idx == 4'd10) fin = 1;
         end
         prev_stall = (rk_valid === 1'b1) && !r;
         prev_key   = round_key;
         prev_idx   = round_idx;
      end
      if (!fin) cap_timeout = 1;
      @(negedge clk);
      start      = 1'b0;
      cap_done1  = done;
      cap_valid1 = rk_valid;
      cap_busy1  = busy;
      if (chain) begin
         key_in = chain_key;
         start  = 1'b1;
         cap_done2 = 1'b0;
      end else begin
         @(negedge clk);
         cap_done2 = done;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
      repeat (2) @(negedge clk);
      total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", round_idx); end
      total++; if (round_key !== 128'h0) begin bad++; $display("FAIL reset_key: got %h want 0", round_key); end
      rst = 1'b0;
      // rk_ready in IDLE does nothing
      rk_ready = 1'b1;
      @(negedge clk);
      total++; if (rk_valid !== 1'b0 || round_idx !== 4'd0) begin bad++; $display("FAIL idle_ready: got valid=%b idx=%0d want 0/0", rk_valid, round_idx); end
   endtask

   task automatic test_fips;
      do_start(FIPS_KEY);
      collect(0, 99, '0, 0, '0);
      total++; if (cap_timeout) begin bad++; $display("FAIL fips_timeout: got %0d keys want 11", cap_n); end
      total++; if (!cap_order_ok) begin bad++; $display("FAIL fips_order: got bad index/valid sequence want 0..10"); end
      total++; if (cap_cycles != 11) begin bad++; $display("FAIL fips_cycles: got %0d want 11", cap_cycles); end
      for (int i = 0; i <= 10; i++) begin
         total++; if (cap_key[i] !== FIPS_RK[i]) begin bad++; $display("FAIL fips_rk%0d: got %h want %h", i, cap_key[i], FIPS_RK[i]); end
      end
      total++; if (cap_done1 !== 1'b1 || cap_valid1 !== 1'b0 || cap_busy1 !== 1'b0) begin
         bad++; $display("FAIL fips_done_cycle: got done=%b valid=%b busy=%b want 1/0/0", cap_done1, cap_valid1, cap_busy1); end
      total++; if (cap_done2 !== 1'b0) begin bad++; $display("FAIL fips_done_pulse: got %b want 0", cap_done2); end
      total++; if (cap_early_done) begin bad++; $display("FAIL fips_early_done: got 1 want 0"); end
   endtask

   task automatic test_zero;
      do_start(128'h0);
      collect(0, 99, '0, 0, '0);
      total++; if (!cap_order_ok || cap_timeout) begin bad++; $display("FAIL zero_order: got %0d keys want 11", cap_n); end
      total++; if (cap_key[0] !== 128'h0) begin bad++; $display("FAIL zero_rk0: got %h want 0", cap_key[0]); end
      total++; if (cap_key[1] !== ZERO_RK1) begin bad++; $display("FAIL zero_rk1: got %h want %h", cap_key[1], ZERO_RK1); end
      total++; if (cap_key[10] !== ZERO_RK10) begin bad++; $display("FAIL zero_rk10: got %h want %h", cap_key[10], ZERO_RK10); end
   endtask

   task automatic test_stall;
      do_start(FIPS_KEY);
      collect(1, 99, '0, 0, '0);
      total++; if (!cap_stable_ok) begin bad++; $display("FAIL stall_stable: got key/idx change while stalled want hold"); end
      total++; if (!cap_order_ok || cap_timeout) begin bad++; $display("FAIL stall_order: got %0d keys want 11 in order", cap_n); end
      for (int i = 0; i <= 10; i++) begin
         total++; if (cap_key[i] !== FIPS_RK[i]) begin bad++; $display("FAIL stall_rk%0d: got %h want %h", i, cap_key[i], FIPS_RK[i]); end
      end
      total++; if (cap_early_done || cap_done1 !== 1'b1) begin bad++; $display("FAIL stall_done: got early=%b after=%b want 0/1", cap_early_done, cap_done1); end
   endtask

   task automatic test_start_ignored;
      do_start(FIPS_KEY);
      collect(0, 4, ALT_KEY, 0, '0);
      total++; if (!cap_order_ok || cap_timeout) begin bad++; $display("FAIL ign_order: got %0d keys want 11 in order", cap_n); end
      for (int i = 0; i <= 10; i++) begin
         total++; if (cap_key[i] !== FIPS_RK[i]) begin bad++; $display("FAIL ign_rk%0d: got %h want %h", i, cap_key[i], FIPS_RK[i]); end
      end
   endtask

   task automatic test_reset_mid;
      bit found;
      found = 0;
      do_start(FIPS_KEY);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         start    = 1'b0;
         rk_ready = 1'b1;
         if (rk_valid === 1'b1 && round_idx == 4'd6) begin
            rst   = 1'b1;
            found = 1;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL rstmid_reach: got no idx6 want idx6"); end
      @(negedge clk);
      rst = 1'b0;
      total++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got valid=%b busy=%b want 0/0", rk_valid, busy); end
      total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL rstmid_idx: got %0d want 0", round_idx); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done0: got %b want 0", done); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done1: got %b want 0", done); end
      do_start(FIPS_KEY);
      collect(0, 99, '0, 0, '0);
      total++; if (!cap_order_ok || cap_timeout) begin bad++; $display("FAIL rstmid_order: got %0d keys want 11", cap_n); end
      for (int i = 0; i <= 10; i++) begin
         total++; if (cap_key[i] !== FIPS_RK[i]) begin bad++; $display("FAIL rstmid_rk%0d: got %h want %h", i, cap_key[i], FIPS_RK[i]); end
      end
   endtask

   task automatic test_back_to_back;
      do_start(FIPS_KEY);
      collect(0, 99, '0, 1, 128'h0);
      total++; if (cap_key[10] !== FIPS_RK[10] || cap_done1 !== 1'b1) begin
         bad++; $display("FAIL b2b_first: got rk10=%h done=%b want %h/1", cap_key[10], cap_done1, FIPS_RK[10]); end
      collect(0, 99, '0, 0, '0);
      total++; if (cap_cycles != 11 || !cap_order_ok) begin bad++; $display("FAIL b2b_cycles: got %0d want 11", cap_cycles); end
      total++; if (cap_key[0] !== 128'h0) begin bad++; $display("FAIL b2b_rk0: got %h want 0", cap_key[0]); end
      total++; if (cap_key[1] !== ZERO_RK1) begin bad++; $display("FAIL b2b_rk1: got %h want %h", cap_key[1], ZERO_RK1); end
      total++; if (cap_key[10] !== ZERO_RK10) begin bad++; $display("FAIL b2b_rk10: got %h want %h", cap_key[10], ZERO_RK10); end
      total++; if (cap_early_done || cap_done1 !== 1'b1 || cap_done2 !== 1'b0) begin
         bad++; $display("FAIL b2b_done: got early=%b d1=%b d2=%b want 0/1/0", cap_early_done, cap_done1, cap_done2); end
   endtask

   initial begin
      test_reset;
      test_fips;
      test_zero;
      test_stall;
      test_start_ignored;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
